// File: rtl/axis_unpack.sv
// axis_unpack: splits one Lanes*DataWidth input word into DataWidth output
// lanes, one lane per accepted output beat, with a 1-cycle latency from
// input transfer to first lane and no bubble between back-to-back words.
//
// Optional feature (macro AXIS_UNPACK_KEEP_EN): adds s_keep_i; lanes whose
// keep bit is 0 are skipped, m_last_o sits on the last kept lane, and an
// all-zero keep word is swallowed without producing output.
//
// The held word and its keep mask are stored in emit order, so position 0
// is always the first lane to leave regardless of LsbFirst.
module axis_unpack #(
  parameter int DataWidth = 8,
  parameter int Lanes     = 2,
  parameter int LsbFirst  = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [Lanes*DataWidth-1:0]   s_data_i,
  input  logic                         s_valid_i,
  input  logic                         s_last_i,
`ifdef AXIS_UNPACK_KEEP_EN
  input  logic [Lanes-1:0]             s_keep_i,
`endif
  output logic                         s_ready_o,
  output logic [DataWidth-1:0]         m_data_o,
  output logic                         m_valid_o,
  output logic                         m_last_o,
  input  logic                         m_ready_i
);

  localparam int CntW = $clog2(Lanes);

  typedef logic [CntW-1:0] cnt_t;
  typedef enum logic {EMPTY, BUSY} state_e;

  // Physical lane index of emit position pos.
  function automatic int phys_lane(input int pos);
    return (LsbFirst != 0) ? pos : (Lanes - 1 - pos);
  endfunction

  // Lowest set mask bit at index >= start, returned as {found, index}.
  function automatic logic [CntW:0] next_kept(input logic [Lanes-1:0] mask,
                                              input int start);
    logic [CntW:0] r;
    r = '0;
    for (int i = Lanes - 1; i >= 0; i--) begin
      if (i >= start && mask[i]) r = {1'b1, cnt_t'(i)};
    end
    return r;
  endfunction

  state_e                       state_q, state_d;
  logic [Lanes*DataWidth-1:0]   word_q, word_d;
  logic [Lanes-1:0]             mask_q, mask_d;
  logic                         last_q, last_d;
  cnt_t                         cnt_q, cnt_d;
  logic [DataWidth-1:0]         m_data_q, m_data_d;
  logic                         m_valid_q, m_valid_d;
  logic                         m_last_q, m_last_d;

  logic [Lanes-1:0]             keep_in;
  logic [Lanes*DataWidth-1:0]   in_word;
  logic [Lanes-1:0]             in_mask;
  logic [CntW:0]                in_first, in_second, cur_next, cur_after;
  logic                         is_final, out_xfer, in_xfer;

`ifdef AXIS_UNPACK_KEEP_EN
  assign keep_in = s_keep_i;
`else
  assign keep_in = '1;
`endif

  // Reorder the incoming word and keep mask into emit order.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a variable unassigned (no latch).
    in_word = '0;
    in_mask = '0;
    for (int i = 0; i < Lanes; i++) begin
      in_word[i*DataWidth +: DataWidth] = s_data_i[phys_lane(i)*DataWidth +: DataWidth];
      in_mask[i]                        = keep_in[phys_lane(i)];
    end
  end

  // Locate first/second kept lanes of the new word and the next kept lanes
  // of the held word; the current lane is final when nothing follows it.
  always_comb begin
    in_first  = next_kept(in_mask, 0);
    in_second = next_kept(in_mask, int'(in_first[CntW-1:0]) + 1);
    cur_next  = next_kept(mask_q, int'(cnt_q) + 1);
    cur_after = next_kept(mask_q, int'(cur_next[CntW-1:0]) + 1);
    is_final  = !cur_next[CntW];
  end

  // Handshakes: a new word is taken when idle or as the final lane leaves.
  always_comb begin
    out_xfer  = m_valid_q && m_ready_i;
    s_ready_o = !rst_i && ((state_q == EMPTY) || (out_xfer && is_final));
    in_xfer   = s_valid_i && s_ready_o;
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    mask_d    = mask_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    if (in_xfer) begin
      word_d = in_word;
      mask_d = in_mask;
      last_d = s_last_i;
      if (in_first[CntW]) begin
        state_d   = BUSY;
        cnt_d     = in_first[CntW-1:0];
        m_valid_d = 1'b1;
        m_data_d  = in_word[int'(in_first[CntW-1:0])*DataWidth +: DataWidth];
        m_last_d  = s_last_i && !in_second[CntW];
      end else begin
        // Nothing kept: the word (and its last flag) vanishes.
        state_d   = EMPTY;
        cnt_d     = '0;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
    end else if (out_xfer) begin
      if (is_final) begin
        state_d   = EMPTY;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end else begin
        cnt_d    = cur_next[CntW-1:0];
        m_data_d = word_q[int'(cur_next[CntW-1:0])*DataWidth +: DataWidth];
        m_last_d = last_q && !cur_after[CntW];
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state updates use non-blocking '<=' so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q   <= EMPTY;
      mask_q    <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  // Held word storage.
  always_ff @(posedge clk_i) begin
    // NOTE: the word register has no reset; it is only read while BUSY,
    // which always follows a load.
    word_q <= word_d;
  end

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;

endmodule

// File: tb/tb_axis_unpack.sv
// Self-checking bench for axis_unpack. A byte-queue reference model predicts
// every output lane, its last flag, m_valid_o and s_ready_o.
module tb_axis_unpack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default-parameter instance (LsbFirst=1, Lanes=2).
  logic [15:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_ready;

  // MSB-first instance.
  logic [15:0] b_s_data;
  logic        b_s_valid, b_s_last, b_s_ready;
  logic [7:0]  b_m_data;
  logic        b_m_valid, b_m_last, b_m_ready;

  axis_unpack u_lsb (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_data_i  (s_data),
    .s_valid_i (s_valid),
    .s_last_i  (s_last),
`ifdef AXIS_UNPACK_KEEP_EN
    .s_keep_i  (2'b11),
`endif
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_valid_o (m_valid),
    .m_last_o  (m_last),
    .m_ready_i (m_ready)
  );

  axis_unpack #(.LsbFirst(0)) u_msb (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_data_i  (b_s_data),
    .s_valid_i (b_s_valid),
    .s_last_i  (b_s_last),
`ifdef AXIS_UNPACK_KEEP_EN
    .s_keep_i  (2'b11),
`endif
    .s_ready_o (b_s_ready),
    .m_data_o  (b_m_data),
    .m_valid_o (b_m_valid),
    .m_last_o  (b_m_last),
    .m_ready_i (b_m_ready)
  );

`ifdef AXIS_UNPACK_KEEP_EN
  logic [31:0] k_s_data;
  logic [3:0]  k_s_keep;
  logic        k_s_valid, k_s_last, k_s_ready;
  logic [7:0]  k_m_data;
  logic        k_m_valid, k_m_last, k_m_ready;

  axis_unpack #(.Lanes(4)) u_keep (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_data_i  (k_s_data),
    .s_valid_i (k_s_valid),
    .s_last_i  (k_s_last),
    .s_keep_i  (k_s_keep),
    .s_ready_o (k_s_ready),
    .m_data_o  (k_m_data),
    .m_valid_o (k_m_valid),
    .m_last_o  (k_m_last),
    .m_ready_i (k_m_ready)
  );
`endif

  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         wfinal;
  } exp_t;

  exp_t expq[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out, n_last;
  int          w, guard;
  bit          acc, sv;
  logic [15:0] rw [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the default instance: drive, predict, compare, advance.
  // Entered and left at a falling edge.
  task automatic step(input bit svi, input logic [15:0] sd, input bit sl,
                      input bit mr, output bit acc_o);
    exp_t e;
    bit   exp_rdy;
    s_valid = svi;
    s_data  = sd;
    s_last  = sl;
    m_ready = mr;
    #1;
    check("m_valid", 32'(m_valid), 32'(expq.size() != 0));
    exp_rdy = 1'b1;
    if (expq.size() != 0) exp_rdy = mr && expq[0].wfinal;
    check("s_ready", 32'(s_ready), 32'(exp_rdy));
    if (m_valid && mr && expq.size() != 0) begin
      e = expq.pop_front();
      check("m_data", 32'(m_data), 32'(e.data));
      check("m_last", 32'(m_last), 32'(e.last));
      n_out++;
      if (m_last) n_last++;
    end
    acc_o = svi && s_ready;
    if (acc_o) begin
      for (int i = 0; i < 2; i++) begin
        expq.push_back('{data: 8'((sd >> (8 * i)) & 16'h00FF),
                         last: sl && (i == 1), wfinal: (i == 1)});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b1;
`ifdef AXIS_UNPACK_KEEP_EN
    k_s_valid = 1'b0; k_s_data = '0; k_s_last = 1'b0; k_s_keep = '0; k_m_ready = 1'b1;
`endif

    // Reset state.
    @(negedge clk);
    s_valid = 1'b1;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);

    // Back-to-back words 0x0100..0x0F0E with m_ready_i=1.
    n_out = 0; n_last = 0; w = 0; guard = 0;
    while (w < 8 && guard < 64) begin
      step(1'b1, {8'(2 * w + 1), 8'(2 * w)}, 1'b0, 1'b1, acc);
      if (acc) w++;
      guard++;
    end
    check("b2b_words", 32'(w), 32'd8);
    check("b2b_cycles", 32'(guard), 32'd15);
    guard = 0;
    while (expq.size() != 0 && guard < 20) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, acc);
      guard++;
    end
    check("b2b_drain", 32'(guard), 32'd2);
    check("b2b_bytes", 32'(n_out), 32'd16);
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);

    // Downstream stall for 5 cycles.
    step(1'b1, 16'hBEEF, 1'b0, 1'b1, acc);
    check("stall_load", 32'(acc), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h1234, 1'b0, 1'b0, acc);
      check("stall_acc", 32'(acc), 32'd0);
      check("stall_data", 32'(m_data), 32'h000000EF);
    end
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);

    // MSB-first: 0xABCD with last -> 0xAB, 0xCD(last).
    b_s_valid = 1'b1; b_s_data = 16'hABCD; b_s_last = 1'b1; b_m_ready = 1'b1;
    #1;
    check("msb_s_ready", 32'(b_s_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    b_s_valid = 1'b0; b_s_last = 1'b0;
    #1;
    check("msb_valid0", 32'(b_m_valid), 32'd1);
    check("msb_data0", 32'(b_m_data), 32'h000000AB);
    check("msb_last0", 32'(b_m_last), 32'd0);
    @(posedge clk); @(negedge clk);
    #1;
    check("msb_valid1", 32'(b_m_valid), 32'd1);
    check("msb_data1", 32'(b_m_data), 32'h000000CD);
    check("msb_last1", 32'(b_m_last), 32'd1);
    @(posedge clk); @(negedge clk);
    #1;
    check("msb_idle", 32'(b_m_valid), 32'd0);
    @(negedge clk);

`ifdef AXIS_UNPACK_KEEP_EN
    // Keep 4'b1010 on 0x44332211 -> 0x22, 0x44(last).
    k_s_valid = 1'b1; k_s_data = 32'h44332211; k_s_keep = 4'b1010; k_s_last = 1'b1;
    #1;
    check("keep_s_ready", 32'(k_s_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    k_s_valid = 1'b0; k_s_last = 1'b0;
    #1;
    check("keep_valid0", 32'(k_m_valid), 32'd1);
    check("keep_data0", 32'(k_m_data), 32'h00000022);
    check("keep_last0", 32'(k_m_last), 32'd0);
    @(posedge clk); @(negedge clk);
    #1;
    check("keep_valid1", 32'(k_m_valid), 32'd1);
    check("keep_data1", 32'(k_m_data), 32'h00000044);
    check("keep_last1", 32'(k_m_last), 32'd1);
    @(posedge clk); @(negedge clk);
    #1;
    check("keep_idle", 32'(k_m_valid), 32'd0);
    // All-zero keep word with last: swallowed, stays idle.
    k_s_valid = 1'b1; k_s_data = 32'hDEADBEEF; k_s_keep = 4'b0000; k_s_last = 1'b1;
    #1;
    check("keep0_s_ready", 32'(k_s_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    k_s_valid = 1'b0; k_s_last = 1'b0;
    #1;
    check("keep0_valid", 32'(k_m_valid), 32'd0);
    check("keep0_ready", 32'(k_s_ready), 32'd1);
    @(negedge clk);
`endif

    // Reset mid-word: 0x3412 emits 0x12, reset drops 0x34, then 0x5678.
    step(1'b1, 16'h3412, 1'b0, 1'b1, acc);
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);
    rst = 1'b1;
    s_valid = 1'b1; s_data = 16'h9999; m_ready = 1'b1;
    #1;
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_data", 32'(m_data), 32'd0);
    check("midrst_m_last", 32'(m_last), 32'd0);
    expq.delete();
    rst = 1'b0;
    s_valid = 1'b0;
    step(1'b1, 16'h5678, 1'b0, 1'b1, acc);
    check("after_rst_acc", 32'(acc), 32'd1);
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);

    // Random handshakes: 16 words, two packets.
    for (int k = 0; k < 16; k++) rw[k] = 16'($urandom);
    n_out = 0; n_last = 0; w = 0; guard = 0;
    while ((w < 16 || expq.size() != 0) && guard < 800) begin
      sv = (w < 16) && ($urandom_range(0, 3) != 0);
      step(sv, sv ? rw[w] : 16'h0, sv && (w == 7 || w == 15),
           $urandom_range(0, 3) != 0, acc);
      if (acc) w++;
      guard++;
    end
    check("rand_in_budget", 32'(guard < 800), 32'd1);
    check("rand_bytes", 32'(n_out), 32'd32);
    check("rand_lasts", 32'(n_last), 32'd2);
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
